// File: rtl/alu_div_pkg.sv
// Shared types and constants for the multi-cycle RV64M divider.
// Operand helpers keep the capture logic in the top module readable.
package alu_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DOING,
        DONE
    } div_state_t;

    localparam int DIV_ITERS = 64;
    localparam int DIV_CNT_W = 7;

    // W variants work on the low word; extension happens before any magnitude is taken.
    function automatic logic [63:0] extendOperand(input logic [63:0] x,
                                                  input logic signedOp,
                                                  input logic wordOp);
        if (!wordOp) begin
            return x;
        end
        return signedOp ? {{32{x[31]}}, x[31:0]} : {32'h0, x[31:0]};
    endfunction

    function automatic logic [63:0] magnitude(input logic [63:0] x, input logic signedOp);
        return (signedOp && x[63]) ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/alu_div_if.sv
// Request/result bundle between the execute stage and the divider.
// Same level-held valid / single-cycle ok handshake as the multiplier.
interface alu_div_if;

    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        signed_op;
    logic        word_op;
    logic        ok;
    logic [63:0] quotient;
    logic [63:0] remainder;

    modport master (
        output valid, a, b, signed_op, word_op,
        input  ok, quotient, remainder
    );

    modport slave (
        input  valid, a, b, signed_op, word_op,
        output ok, quotient, remainder
    );

endinterface

// File: rtl/div_sign_fix.sv
// Turns unsigned quotient/remainder magnitudes into RV64M results:
// sign restore, divide-by-zero override, then W-variant sign extension.
module div_sign_fix (
    input  logic [63:0] quo_i,
    input  logic [63:0] rem_i,
    input  logic [63:0] dividend_i,
    input  logic        negQuot_i,
    input  logic        negRem_i,
    input  logic        dz_i,
    input  logic        word_i,
    output logic [63:0] quo_o,
    output logic [63:0] rem_o
);

    logic [63:0] quoFix;
    logic [63:0] remFix;

    always_comb begin
        quoFix = negQuot_i ? (~quo_i + 64'd1) : quo_i;
        remFix = negRem_i ? (~rem_i + 64'd1) : rem_i;
        if (dz_i) begin
            quoFix = '1;
            remFix = dividend_i;
        end
        // Unsigned W results are sign-extended from bit 31 as well.
        quo_o = word_i ? {{32{quoFix[31]}}, quoFix[31:0]} : quoFix;
        rem_o = word_i ? {{32{remFix[31]}}, remFix[31:0]} : remFix;
    end

endmodule

// File: rtl/alu_div.sv
// Radix-2 restoring divider, one quotient bit per cycle, 65-cycle fixed latency.
// The dividend magnitude shifts out of the quotient register into the partial remainder.
module alu_div
    import alu_div_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    alu_div_if.slave  bus
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] count_q, count_d;
    logic [63:0]          partRem_q, partRem_d;
    logic [63:0]          workQuo_q, workQuo_d;
    logic [63:0]          divisor_q, divisor_d;
    logic [63:0]          dividend_q, dividend_d;
    logic                 dz_q, dz_d;
    logic                 negQuot_q, negQuot_d;
    logic                 negRem_q, negRem_d;
    logic                 wordOp_q, wordOp_d;
    logic [63:0]          quotient_q, quotient_d;
    logic [63:0]          remainder_q, remainder_d;

    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [64:0] partial;
    logic [63:0] diff;
    logic        takeBit;
    logic [63:0] stepRem;
    logic [63:0] stepQuo;
    logic [63:0] fixQuo;
    logic [63:0] fixRem;

    assign aExt = extendOperand(bus.a, bus.signed_op, bus.word_op);
    assign bExt = extendOperand(bus.b, bus.signed_op, bus.word_op);

    // The partial remainder needs 65 bits; a passing difference always fits back into 64.
    assign partial = {partRem_q, workQuo_q[63]};
    assign takeBit = (partial >= {1'b0, divisor_q});
    assign diff    = partial[63:0] - divisor_q;
    assign stepRem = takeBit ? diff : partial[63:0];
    assign stepQuo = {workQuo_q[62:0], takeBit};

    div_sign_fix u_signFix (
        .quo_i      (stepQuo),
        .rem_i      (stepRem),
        .dividend_i (dividend_q),
        .negQuot_i  (negQuot_q),
        .negRem_i   (negRem_q),
        .dz_i       (dz_q),
        .word_i     (wordOp_q),
        .quo_o      (fixQuo),
        .rem_o      (fixRem)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        partRem_d   = partRem_q;
        workQuo_d   = workQuo_q;
        divisor_d   = divisor_q;
        dividend_d  = dividend_q;
        dz_d        = dz_q;
        negQuot_d   = negQuot_q;
        negRem_d    = negRem_q;
        wordOp_d    = wordOp_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_d    = DOING;
                    count_d    = DIV_CNT_W'(DIV_ITERS);
                    partRem_d  = '0;
                    workQuo_d  = magnitude(aExt, bus.signed_op);
                    divisor_d  = magnitude(bExt, bus.signed_op);
                    dividend_d = aExt;
                    dz_d       = (bExt == 64'd0);
                    negQuot_d  = bus.signed_op & (aExt[63] ^ bExt[63]);
                    negRem_d   = bus.signed_op & aExt[63];
                    wordOp_d   = bus.word_op;
                end
            end
            DOING: begin
                if (!bus.valid) begin
                    state_d = IDLE;
                end else begin
                    partRem_d = stepRem;
                    workQuo_d = stepQuo;
                    count_d   = count_q - DIV_CNT_W'(1);
                    if (count_q == DIV_CNT_W'(1)) begin
                        state_d     = DONE;
                        quotient_d  = fixQuo;
                        remainder_d = fixRem;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            partRem_q   <= '0;
            workQuo_q   <= '0;
            divisor_q   <= '0;
            dividend_q  <= '0;
            dz_q        <= 1'b0;
            negQuot_q   <= 1'b0;
            negRem_q    <= 1'b0;
            wordOp_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            partRem_q   <= partRem_d;
            workQuo_q   <= workQuo_d;
            divisor_q   <= divisor_d;
            dividend_q  <= dividend_d;
            dz_q        <= dz_d;
            negQuot_q   <= negQuot_d;
            negRem_q    <= negRem_d;
            wordOp_q    <= wordOp_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.ok        = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed vector table, handshake corner
// sequences, and random operations against an arithmetic RV64M reference model.
module tb_alu_div;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_div_if dif ();

    alu_div dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        signedOp;
        logic        wordOp;
        logic [63:0] expQ;
        logic [63:0] expR;
    } vec_t;

    vec_t vecs[11];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // RISC-V division semantics straight from the ISA rules, using native SV arithmetic.
    function automatic void refModel(input logic [63:0] a, input logic [63:0] b,
                                     input logic s, input logic w,
                                     output logic [63:0] q, output logic [63:0] r);
        int                sa32, sb32;
        int unsigned       ua32, ub32;
        longint            sa64, sb64;
        longint unsigned   ua64, ub64;
        logic [31:0]       q32, r32;
        if (w) begin
            if (b[31:0] == 32'd0) begin
                q = '1;
                r = {{32{a[31]}}, a[31:0]};
                return;
            end
            if (s) begin
                sa32 = a[31:0];
                sb32 = b[31:0];
                if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                    q32 = 32'h8000_0000;
                    r32 = 32'd0;
                end else begin
                    q32 = sa32 / sb32;
                    r32 = sa32 % sb32;
                end
            end else begin
                ua32 = a[31:0];
                ub32 = b[31:0];
                q32  = ua32 / ub32;
                r32  = ua32 % ub32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1;
                r = a;
                return;
            end
            if (s) begin
                sa64 = a;
                sb64 = b;
                if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                    q = 64'h8000_0000_0000_0000;
                    r = 64'd0;
                end else begin
                    q = sa64 / sb64;
                    r = sa64 % sb64;
                end
            end else begin
                ua64 = a;
                ub64 = b;
                q    = ua64 / ub64;
                r    = ua64 % ub64;
            end
        end
    endfunction

    task automatic waitOk(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (dif.ok === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic w,
                                 input logic [63:0] expQ, input logic [63:0] expR);
        int n;
        @(negedge clk);
        dif.a         = a;
        dif.b         = b;
        dif.signed_op = s;
        dif.word_op   = w;
        dif.valid     = 1'b1;
        waitOk(n);
        checkOutput({name, " latency"}, 64'(n), 64'd65);
        checkOutput({name, " quotient"}, dif.quotient, expQ);
        checkOutput({name, " remainder"}, dif.remainder, expR);
        dif.valid = 1'b0;
        @(negedge clk);
        checkOutput({name, " ok low after done"}, 64'(dif.ok), 64'd0);
        checkOutput({name, " quotient held"}, dif.quotient, expQ);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int          okSeen;
        logic [63:0] ra, rb, rq, rr;
        logic        rs, rw;

        checks = 0;
        errors = 0;

        vecs[0]  = '{"u100_7",      64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2};
        vecs[1]  = '{"s-7_2",       64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2]  = '{"s7_-2",       64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
        vecs[3]  = '{"s-5_0",       64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};
        vecs[4]  = '{"wu_dz",       64'h0000_0001_8000_0000, 64'd0, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vecs[5]  = '{"s_ovf",       64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'h8000_0000_0000_0000, 64'd0};
        vecs[6]  = '{"ws_ovf",      64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 64'd0};
        vecs[7]  = '{"wu_ffff_2",   64'h0000_0000_FFFF_FFFF, 64'd2, 1'b0, 1'b1,
                     64'h0000_0000_7FFF_FFFF, 64'd1};
        vecs[8]  = '{"wu_fffe_1",   64'h1234_5678_FFFF_FFFE, 64'd1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
        vecs[9]  = '{"u_max_1",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[10] = '{"u_5_bigdiv",  64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 64'd5};

        dif.valid     = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.signed_op = 1'b0;
        dif.word_op   = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset ok", 64'(dif.ok), 64'd0);
        checkOutput("reset quotient", dif.quotient, 64'd0);
        checkOutput("reset remainder", dif.remainder, 64'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].signedOp, vecs[i].wordOp,
                          vecs[i].expQ, vecs[i].expR);
        end

        // Abort: a dropped valid must leave the previous 100/7 result in place.
        applyStimulus("abort pre", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2);
        @(negedge clk);
        dif.a     = 64'd50;
        dif.b     = 64'd3;
        dif.valid = 1'b1;
        okSeen    = 0;
        repeat (30) begin
            @(negedge clk);
            if (dif.ok === 1'b1) okSeen++;
        end
        dif.valid = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (dif.ok === 1'b1) okSeen++;
        end
        checkOutput("abort no ok", 64'(okSeen), 64'd0);
        checkOutput("abort quotient", dif.quotient, 64'd14);
        checkOutput("abort remainder", dif.remainder, 64'd2);

        // Reset mid-operation with valid still high: reset wins and nothing starts.
        dif.valid = 1'b1;
        okSeen    = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ok === 1'b1) okSeen++;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        dif.valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset quotient", dif.quotient, 64'd0);
        checkOutput("midreset remainder", dif.remainder, 64'd0);
        repeat (70) begin
            @(negedge clk);
            if (dif.ok === 1'b1) okSeen++;
        end
        checkOutput("midreset no ok", 64'(okSeen), 64'd0);
        applyStimulus("after reset", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2);

        // Back-to-back issue with an operand change during DOING that must be ignored.
        @(negedge clk);
        dif.a         = 64'd1000;
        dif.b         = 64'd9;
        dif.signed_op = 1'b0;
        dif.word_op   = 1'b0;
        dif.valid     = 1'b1;
        n             = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 10) begin
                dif.a = 64'd77;
                dif.b = 64'd5;
            end
            if (dif.ok === 1'b1) begin
                n = i;
                break;
            end
        end
        checkOutput("b2b first latency", 64'(n), 64'd65);
        checkOutput("b2b first quotient", dif.quotient, 64'd111);
        checkOutput("b2b first remainder", dif.remainder, 64'd1);
        dif.a         = 64'hFFFF_FFFF_FFFF_FF9C;
        dif.b         = 64'd8;
        dif.signed_op = 1'b1;
        waitOk(n);
        checkOutput("b2b second latency", 64'(n), 64'd66);
        checkOutput("b2b second quotient", dif.quotient, 64'hFFFF_FFFF_FFFF_FFF4);
        checkOutput("b2b second remainder", dif.remainder, 64'hFFFF_FFFF_FFFF_FFFC);
        dif.valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b ok low", 64'(dif.ok), 64'd0);

        // Random operations, biased toward small, zero and word-sized divisors.
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: rb = {$urandom, $urandom};
                1: rb = 64'($urandom_range(1, 1000));
                2: rb = 64'd0;
                default: rb = {32'h0, $urandom};
            endcase
            if (rs && $urandom_range(0, 1) == 1) rb = ~rb + 64'd1;
            if ($urandom_range(0, 4) == 0) ra = 64'h8000_0000_0000_0000;
            refModel(ra, rb, rs, rw, rq, rr);
            applyStimulus($sformatf("rand%0d", i), ra, rb, rs, rw, rq, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
